// File: rtl/pipo_pkg.sv
// rtl/pipo_pkg.sv - shared mode and FSM state encodings for pipo_univ_shreg
//
// Purpose : manual-mode opcodes and auto-serialise FSM state encodings.
// Ports   : none (package).

package pipo_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shreg_next.sv
// rtl/shreg_next.sv - combinational next-value mux for the manual modes
//
// Purpose : computes the value q would take for a given manual mode.
// Ports   : q_i      current register contents
//           mode_i   manual operation select
//           din_i    parallel load data
//           si_msb_i serial bit entering the MSB on right shifts
//           si_lsb_i serial bit entering the LSB on left shifts
//           q_next_o candidate next value

module shreg_next
    import pipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             si_msb_i,
    input  logic             si_lsb_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_LOAD: q_next_o = din_i;
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], si_lsb_i};
            MODE_SHR:  q_next_o = {si_msb_i, q_i[WIDTH-1:1]};
            MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            // MODE_HOLD and the reserved encoding keep q unchanged
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/pipo_univ_shreg.sv
// rtl/pipo_univ_shreg.sv - WIDTH-bit universal shift register with auto-serialise
//
// Purpose : universal register (hold/load/shift/rotate/asr) plus an FSM that
//           loads a word and shifts it out LSB-first over WIDTH cycles.
// Ports   : clk, rst (async active-low)
//           en, mode, din, si_msb, si_lsb   manual-mode controls and data
//           start                            auto-serialise request
//           q, qbar, so_msb, so_lsb          register value and serial taps
//           busy, done, cnt                  serialise status

module pipo_univ_shreg
    import pipo_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             din,
    input  logic                         si_msb,
    input  logic                         si_lsb,
    input  logic                         start,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qbar,
    output logic                         so_msb,
    output logic                         so_lsb,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   cnt
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  manual_next;

    shreg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q_i      (q_q),
        .mode_i   (mode),
        .din_i    (din),
        .si_msb_i (si_msb),
        .si_lsb_i (si_lsb),
        .q_next_o (manual_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus datapath: start wins over manual modes in IDLE, and
    // every input except si_msb is ignored once serialising has begun.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    q_d     = din;
                    cnt_d   = '0;
                end else if (en) begin
                    q_d = manual_next;
                end
            end
            ST_SHIFT: begin
                q_d   = {si_msb, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // this edge performs the WIDTH-th shift
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    assign q      = q_q;
    assign qbar   = ~q_q;
    assign so_msb = q_q[WIDTH-1];
    assign so_lsb = q_q[0];
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_pipo_univ_shreg.sv
// tb/tb_pipo_univ_shreg.sv - self-checking bench for pipo_univ_shreg

module tb_pipo_univ_shreg;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic         si_msb;
    logic         si_lsb;
    logic         start;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         so_msb;
    logic         so_lsb;
    logic         busy;
    logic         done;
    logic [2:0]   cnt;

    int total = 0;
    int bad   = 0;
    int m_q   = 0;

    pipo_univ_shreg #(
        .WIDTH   (W),
        .RST_VAL (4'b0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .din    (din),
        .si_msb (si_msb),
        .si_lsb (si_lsb),
        .start  (start),
        .q      (q),
        .qbar   (qbar),
        .so_msb (so_msb),
        .so_lsb (so_lsb),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for manual modes, written as integer arithmetic on the value.
    function automatic int model_manual(int qv, int md, int dv, int sm, int sl);
        case (md)
            1: return dv;
            2: return (qv * 2 + sl) % M;
            3: return qv / 2 + sm * (M / 2);
            4: return (qv * 2) % M + qv / (M / 2);
            5: return qv / 2 + (qv % 2) * (M / 2);
            6: return qv / 2 + ((qv >= M / 2) ? M / 2 : 0);
            default: return qv;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; mode = 3'b000; din = '0;
        si_msb = 1'b0; si_lsb = 1'b0; start = 1'b0;
        tick(); tick();
        total++; if (q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b want=0000", q); end
        total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL reset_qbar got=%b want=1111", qbar); end
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        rst = 1'b1;
        en = 1'b1; mode = 3'b001; din = 4'b1010;
        tick();
        en = 1'b0;
        total++; if (q !== 4'b1010) begin bad++; $display("FAIL pre_reset_load got=%b want=1010", q); end
        #2 rst = 1'b0;
        #1;
        total++; if (q !== 4'b0000) begin bad++; $display("FAIL async_reset_q got=%b want=0000", q); end
        total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL async_reset_qbar got=%b want=1111", qbar); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL async_reset_status got=%b%b want=00", busy, done); end
        tick();
        rst = 1'b1;
        m_q = 0;
    endtask

    task automatic test_load_hold();
        en = 1'b1; mode = 3'b001; din = 4'b1011;
        tick();
        total++; if (q !== 4'b1011) begin bad++; $display("FAIL load_q got=%b want=1011", q); end
        total++; if (qbar !== 4'b0100) begin bad++; $display("FAIL load_qbar got=%b want=0100", qbar); end
        en = 1'b0; mode = 3'b010; si_lsb = 1'b1;
        tick();
        total++; if (q !== 4'b1011) begin bad++; $display("FAIL hold_en0 got=%b want=1011", q); end
        m_q = 11;
    endtask

    task automatic test_shifts();
        logic [2:0] modes [4];
        logic [3:0] wants [4];
        modes = '{3'b010, 3'b101, 3'b110, 3'b011};
        wants = '{4'b0111, 4'b1011, 4'b1101, 4'b0110};
        en = 1'b1; si_lsb = 1'b1; si_msb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            tick();
            total++;
            if (q !== wants[i]) begin
                bad++; $display("FAIL shift_step%0d mode=%b got=%b want=%b", i, modes[i], q, wants[i]);
            end
        end
        en = 1'b0;
        m_q = 6;
    endtask

    // Runs one serialise of dval; when noisy, hammers start/din/en/mode while busy.
    task automatic run_serialise(input logic [W-1:0] dval, input bit noisy, input string tag);
        logic [W-1:0] exp_q;
        exp_q = '0;
        start = 1'b1; din = dval; si_msb = 1'b0; en = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            if (k <= W) begin
                total++; if (so_lsb !== dval[k-1]) begin bad++; $display("FAIL %s so_lsb_c%0d got=%b want=%b", tag, k, so_lsb, dval[k-1]); end
                total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s status_c%0d got=%b%b want=10", tag, k, busy, done); end
                total++; if (cnt !== 3'(k - 1)) begin bad++; $display("FAIL %s cnt_c%0d got=%0d want=%0d", tag, k, cnt, k - 1); end
            end else begin
                total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL %s done_pulse got=%b%b want=01", tag, busy, done); end
                total++; if (cnt !== 3'(W)) begin bad++; $display("FAIL %s cnt_done got=%0d want=%0d", tag, cnt, W); end
                total++; if (q !== 4'b0000) begin bad++; $display("FAIL %s q_done got=%b want=0000", tag, q); end
            end
            if (noisy && k >= 2) begin
                start = 1'b1; din = 4'b1111; en = 1'b1; mode = 3'b001;
            end
            tick();
        end
        start = 1'b0; en = 1'b0; mode = 3'b000;
        for (int k = 0; k < 2; k++) begin
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after_done%0d got=%b%b want=00", tag, k, busy, done); end
            total++; if (q !== exp_q || cnt !== 3'(W)) begin bad++; $display("FAIL %s hold_after q=%b cnt=%0d want q=%b cnt=%0d", tag, q, cnt, exp_q, W); end
            tick();
        end
        m_q = 0;
    endtask

    task automatic test_serialise();
        run_serialise(4'b1101, 1'b0, "serialise");
    endtask

    task automatic test_interference();
        run_serialise(4'b1101, 1'b1, "interfere");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; din = 4'b1011; si_msb = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        total++; if (cnt !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL midrst_pre cnt=%0d busy=%b want cnt=2 busy=1", cnt, busy); end
        #2 rst = 1'b0;
        #1;
        total++; if (q !== 4'b0000 || busy !== 1'b0 || cnt !== 3'd0) begin bad++; $display("FAIL midrst_now q=%b busy=%b cnt=%0d want 0000 0 0", q, busy, cnt); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < W + 3; k++) begin
            tick();
            total++; if (done !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin bad++; $display("FAIL midrst_after%0d q=%b busy=%b done=%b want 0000 0 0", k, q, busy, done); end
        end
        si_msb = 1'b0;
        m_q = 0;
    endtask

    task automatic test_random_manual();
        for (int i = 0; i < 60; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            din = 4'($urandom_range(0, M - 1));
            si_msb = 1'($urandom_range(0, 1));
            si_lsb = 1'($urandom_range(0, 1));
            if (en) m_q = model_manual(m_q, int'(mode), int'(din), int'(si_msb), int'(si_lsb));
            tick();
            total++; if (q !== 4'(m_q)) begin bad++; $display("FAIL rand_manual%0d en=%b mode=%b got=%b want=%b", i, en, mode, q, 4'(m_q)); end
            total++; if (qbar !== ~4'(m_q) || so_lsb !== 1'(m_q % 2) || so_msb !== 1'(m_q / (M / 2))) begin
                bad++; $display("FAIL rand_taps%0d qbar=%b so=%b%b", i, qbar, so_msb, so_lsb);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random_serialise();
        logic [W-1:0] dval;
        int exp_q;
        for (int r = 0; r < 6; r++) begin
            dval = 4'($urandom_range(0, M - 1));
            exp_q = 0;
            start = 1'b1; din = dval; en = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
            tick();
            for (int k = 1; k <= W + 1; k++) begin
                if (k <= W) begin
                    total++; if (so_lsb !== dval[k-1] || busy !== 1'b1) begin bad++; $display("FAIL rser%0d c%0d so=%b busy=%b want so=%b busy=1", r, k, so_lsb, busy, dval[k-1]); end
                end else begin
                    total++; if (done !== 1'b1 || q !== 4'(exp_q)) begin bad++; $display("FAIL rser%0d done=%b q=%b want done=1 q=%b", r, done, q, 4'(exp_q)); end
                end
                si_msb = 1'($urandom_range(0, 1));
                if (k <= W) exp_q = exp_q + int'(si_msb) * (1 << (k - 1));
                start = 1'($urandom_range(0, 1));
                en = 1'($urandom_range(0, 1));
                mode = 3'($urandom_range(0, 7));
                din = 4'($urandom_range(0, M - 1));
                tick();
            end
            start = 1'b0; en = 1'b0;
            total++; if (done !== 1'b0 || q !== 4'(exp_q)) begin bad++; $display("FAIL rser%0d post done=%b q=%b want done=0 q=%b", r, done, q, 4'(exp_q)); end
            tick();
            m_q = exp_q;
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shifts();
        test_serialise();
        test_interference();
        test_reset_mid();
        test_random_manual();
        test_random_serialise();
        test_random_manual();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
